input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions one raw asynchronous input, such as a push-button or switch, into a clean synchronous level and single-cycle edge pulses. It sits directly upstream of the team's registered datapath flops and drives their `d`/enable inputs. The raw pin is synchronized through a flop chain and must be held at a new level for a programmable number of cycles before the output level changes. A wrapping event counter records accepted rising edges.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; legal range ≥ 2.
- `STABLE_CYCLES`, default 1000: consecutive synchronized samples required to accept a new level; legal range 2 … 2**CNT_W−1.
- `CNT_W`, default 16: debounce counter width.
- `EVT_W`, default 8: rising-edge event counter width.
- `clk` in, 1: sole clock; everything is sampled on the rising edge.
- `rst` in, 1: reset, synchronous and active-low. It takes effect only at a `clk` rising edge while `rst`=0.
- `din` in, 1: raw asynchronous input.
- `dout` out, 1: debounced level, registered.
- `rise` out, 1: one-cycle pulse in the cycle `dout` goes 0→1, registered.
- `fall` out, 1: one-cycle pulse in the cycle `dout` goes 1→0, registered.
- `evt_cnt` out, `EVT_W`: count of accepted rising edges, wraps modulo 2**EVT_W.

## Operation
- **Synchronizer.** `din` passes through `SYNC_STAGES` flops. The last stage output is `s`. No logic may read any earlier stage.
- **States:** `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`. Encoding is 2 bits, as local constants.
- `IDLE_LO`
  - `s`=1: go to `WAIT_HI` with `cnt`←1.
  - Otherwise stay, with `cnt`←0.
- `WAIT_HI`
  - `s`=0: glitch rejected. Go to `IDLE_LO` with `cnt`←0. No output change.
  - `s`=1 and `cnt`=`STABLE_CYCLES`−1: go to `IDLE_HI` with `dout`←1, `rise`←1, `evt_cnt`←`evt_cnt`+1, `cnt`←0.
  - `s`=1 otherwise: `cnt`←`cnt`+1.
- `IDLE_HI` and `WAIT_LO` mirror the two cases above with polarity inverted. Completion sets `dout`←0 and `fall`←1. `evt_cnt` is unchanged on falls.
- **Pulses.** `rise` and `fall` are cleared on every edge where they are not being set. They are never high together and never high for two consecutive cycles.
- **Counter behaviour.** `cnt` never exceeds `STABLE_CYCLES`−1 and never wraps. `evt_cnt` wraps from 2**EVT_W−1 to 0 with no flag.

## Timing
- **Reset values.** When `rst`=0 at an edge:
  - `dout`=0, `rise`=0, `fall`=0, `evt_cnt`=0.
  - `cnt`=0, all synchronizer flops=0, state=`IDLE_LO`.
- **Reset mid-wait.** A reset during `WAIT_*` aborts the wait. No pulse is emitted.
- **High input after reset.** If `din` is held high through reset release, it is accepted as a normal rising edge once the latency below has elapsed.
- **Latency.** Let edge k be the first edge at which synchronizer stage 1 captures a new `din` level, with the level held afterwards. Then `dout`, `rise` or `fall`, and `evt_cnt` update at edge k + `SYNC_STAGES` + `STABLE_CYCLES` − 1. With defaults 2 and 1000, that is k+1001.
- **Glitch rejection.** Any excursion of `s` lasting fewer than `STABLE_CYCLES` consecutive samples produces no output change.
- **Minimum spacing.** Two accepted edges are at least `STABLE_CYCLES` cycles apart.
- **No combinational paths.** All outputs change only at `clk` edges. There is no combinational path from `din` to any output.

## Structure
- Sub-module `sync_chain`: parameterized `SYNC_STAGES`-deep flop chain with the same synchronous active-low `rst`. It is reused elsewhere for other async inputs.
- **Kept local.** State encodings and the FSM stay as `localparam`s inside `input_debouncer`.
- **Shared header.** Only the default `STABLE_CYCLES` value for the board clock belongs in the project's shared constants include.
- **Expected size.** About 150–200 lines total.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `STABLE_CYCLES`=4, with a 20 ns clock.
- **Reset.** Hold `rst`=0 for 3 edges with `din`=1 → `dout`=0, `rise`=`fall`=0, `evt_cnt`=0. Release reset → `dout`=1 and one `rise` pulse at release-edge + 5, then `evt_cnt`=1.
- **Clean press.** `din` 0→1 before edge k and held → `dout`=1 and `rise`=1 exactly at edge k+5. `rise`=0 at k+6. `evt_cnt` goes 0→1.
- **Glitch.** `din` high for 3 cycles, then low → `dout` stays 0, no `rise`, and the FSM returns to `IDLE_LO`. A 4-cycle-high pulse is accepted.
- **Release.** From `dout`=1, `din`→0 and held → `fall`=1 and `dout`=0 at k+5. `evt_cnt` is unchanged.
- **Reset mid-wait.** Assert `rst`=0 on the 3rd cycle of `WAIT_HI` → `dout`=0, no pulse, `evt_cnt` unchanged.
- **Wrap.** Drive 256 accepted presses with `EVT_W`=8 → `evt_cnt` reads 255, then 0 on the 256th. `rise` count equals 256.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared project constants for the input debouncer.
// Only the board-clock default for the stability window lives here; the FSM
// encoding stays private to the debouncer itself.
package input_debouncer_pkg;

    // Default stability window in board-clock cycles.
    localparam int DEFAULT_STABLE_CYCLES = 1000;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Only the last stage is exposed; earlier stages may be metastable and must
// never be read by downstream logic.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage;

    // Shift the raw input through the chain; clear on synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is sampled like any
        // other input inside the clocked block rather than in the sensitivity list.
        if (!rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw asynchronous input into a registered level, single-cycle
// rise/fall pulses and a wrapping count of accepted rising edges.
// A new level is accepted only after STABLE_CYCLES consecutive synchronized
// samples at that level; the first sample is the one that leaves the idle state.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 16,
    parameter int EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_cnt
);

    // Debounce FSM encoding, private to this block.
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (s)
    );

    // Debounce FSM with registered level, edge pulses and event counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            dout    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            evt_cnt <= '0;
        end else begin
            // NOTE: pulses default low here and are overridden below by the
            // later non-blocking assignment, so each lasts exactly one cycle.
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (s) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_HI;
                        cnt     <= '0;
                        dout    <= 1'b1;
                        rise    <= 1'b1;
                        evt_cnt <= evt_cnt + EVT_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// With din changed after edge k-1, stage 1 captures it at edge k and the
// outputs must update at edge k+5, i.e. on the 6th tick after the change.
module tb_input_debouncer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 16;
    localparam int EVT_W         = 8;

    logic             clk;
    logic             rst;
    logic             din;
    logic             dout;
    logic             rise;
    logic             fall;
    logic [EVT_W-1:0] evt_cnt;

    int vectors;
    int miscompares;
    int rise_total;
    int fall_total;
    logic prev_rise;
    logic prev_fall;

    input_debouncer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .EVT_W        (EVT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .evt_cnt(evt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Pulse monitor sampled on the falling edge, away from the active edge.
    initial begin
        prev_rise  = 1'b0;
        prev_fall  = 1'b0;
        rise_total = 0;
        fall_total = 0;
        forever begin
            @(negedge clk);
            if (rise) rise_total++;
            if (fall) fall_total++;
            if (rise && fall) begin
                miscompares++;
                $display("FAIL pulse_overlap: rise=%0b fall=%0b, required not both high", rise, fall);
            end
            if ((rise && prev_rise) || (fall && prev_fall)) begin
                miscompares++;
                $display("FAIL pulse_width: rise=%0b/%0b fall=%0b/%0b, required single-cycle", prev_rise, rise, prev_fall, fall);
            end
            prev_rise = rise;
            prev_fall = fall;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_outputs(input string name, input logic e_dout, input logic e_rise,
                                  input logic e_fall, input logic [EVT_W-1:0] e_evt);
        vectors++;
        if (dout !== e_dout || rise !== e_rise || fall !== e_fall || evt_cnt !== e_evt) begin
            miscompares++;
            $display("FAIL %s: got dout=%0b rise=%0b fall=%0b evt=%0d, required dout=%0b rise=%0b fall=%0b evt=%0d",
                     name, dout, rise, fall, evt_cnt, e_dout, e_rise, e_fall, e_evt);
        end
    endtask

    // Reset with din high, then high input accepted after release.
    task automatic test_reset();
        rst = 1'b0;
        din = 1'b1;
        tick(3);
        expect_outputs("reset_values", 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        tick(5);
        expect_outputs("reset_release_k4", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        expect_outputs("reset_release_k5", 1'b1, 1'b1, 1'b0, 8'd1);
        tick(1);
        expect_outputs("reset_release_k6", 1'b1, 1'b0, 1'b0, 8'd1);
    endtask

    // Level release: fall at k+5, event count unchanged.
    task automatic test_release(input string name, input logic [EVT_W-1:0] e_evt);
        din = 1'b0;
        tick(5);
        expect_outputs({name, "_k4"}, 1'b1, 1'b0, 1'b0, e_evt);
        tick(1);
        expect_outputs({name, "_k5"}, 1'b0, 1'b0, 1'b1, e_evt);
        tick(1);
        expect_outputs({name, "_k6"}, 1'b0, 1'b0, 1'b0, e_evt);
    endtask

    // Clean press: rise at k+5, gone at k+6.
    task automatic test_clean_press(input logic [EVT_W-1:0] e_evt_before);
        logic [EVT_W-1:0] e_after;
        e_after = e_evt_before + 8'd1;
        din = 1'b1;
        tick(5);
        expect_outputs("press_k4", 1'b0, 1'b0, 1'b0, e_evt_before);
        tick(1);
        expect_outputs("press_k5", 1'b1, 1'b1, 1'b0, e_after);
        tick(1);
        expect_outputs("press_k6", 1'b1, 1'b0, 1'b0, e_after);
    endtask

    // Three-cycle pulse is rejected; four-cycle pulse is accepted.
    task automatic test_glitch(input logic [EVT_W-1:0] e_evt);
        int rises_before;
        rises_before = rise_total;
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(8);
        expect_outputs("glitch3_reject", 1'b0, 1'b0, 1'b0, e_evt);
        vectors++;
        if (rise_total !== rises_before) begin
            miscompares++;
            $display("FAIL glitch3_rise_count: got %0d rises, required %0d", rise_total, rises_before);
        end
        din = 1'b1;
        tick(4);
        din = 1'b0;
        tick(1);
        expect_outputs("glitch4_k4", 1'b0, 1'b0, 1'b0, e_evt);
        tick(1);
        expect_outputs("glitch4_accept", 1'b1, 1'b1, 1'b0, e_evt + 8'd1);
        tick(3);
        expect_outputs("glitch4_k8", 1'b1, 1'b0, 1'b0, e_evt + 8'd1);
        tick(1);
        expect_outputs("glitch4_fall", 1'b0, 1'b0, 1'b1, e_evt + 8'd1);
        tick(2);
    endtask

    // Reset asserted during the third WAIT_HI cycle aborts the acceptance.
    task automatic test_reset_mid_wait();
        int rises_before;
        rises_before = rise_total;
        din = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        expect_outputs("midwait_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        din = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(8);
        expect_outputs("midwait_after", 1'b0, 1'b0, 1'b0, 8'd0);
        vectors++;
        if (rise_total !== rises_before) begin
            miscompares++;
            $display("FAIL midwait_rise_count: got %0d rises, required %0d", rise_total, rises_before);
        end
    endtask

    // 256 accepted presses wrap the 8-bit event counter back to zero.
    task automatic test_wrap();
        int rises_before;
        logic [EVT_W-1:0] e_evt;
        rises_before = rise_total;
        e_evt = 8'd0;
        for (int p = 1; p <= 256; p++) begin
            din = 1'b1;
            tick(6);
            e_evt = e_evt + 8'd1;
            vectors++;
            if (dout !== 1'b1 || rise !== 1'b1 || evt_cnt !== e_evt) begin
                miscompares++;
                $display("FAIL wrap_press_%0d: got dout=%0b rise=%0b evt=%0d, required dout=1 rise=1 evt=%0d",
                         p, dout, rise, evt_cnt, e_evt);
            end
            if (p == 255) expect_outputs("wrap_255", 1'b1, 1'b1, 1'b0, 8'd255);
            if (p == 256) expect_outputs("wrap_256", 1'b1, 1'b1, 1'b0, 8'd0);
            din = 1'b0;
            tick(6);
        end
        tick(1);
        vectors++;
        if (rise_total - rises_before !== 256) begin
            miscompares++;
            $display("FAIL wrap_rise_count: got %0d rises, required 256", rise_total - rises_before);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        din = 1'b0;
        test_reset();
        test_release("release1", 8'd1);
        test_clean_press(8'd1);
        test_release("release2", 8'd2);
        test_glitch(8'd2);
        test_reset_mid_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
